// File: rtl/bus_tx_queue.sv
// Transmit queue for one device on the shared tri-state bus: buffers device writes,
// requests the bus, pops one word per granted cycle and caps each tenure at MAX_BURST words.
module bus_tx_queue #(
  parameter int N         = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int GAP       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [N-1:0]                 wr_data,
  output logic                         wr_ready,
  input  logic                         grant,
  output logic                         req,
  output logic [N-1:0]                 bus_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(MAX_BURST+1);
  localparam int GW = $clog2(GAP+2);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST-1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? GAP-1 : 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, BACKOFF} state_t;

  state_t          state;
  logic [N-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [BW-1:0]   burst_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            push, pop;
  logic [CW-1:0]   count_next;

  assign wr_ready   = (count != CW'(DEPTH));
  assign push       = wr_valid & wr_ready;
  assign pop        = (state == ACTIVE) & req & grant & (count != '0);
  assign count_next = count + CW'(push) - CW'(pop);
  // Head word goes straight to the bus driver; forced to zero so an empty queue drives a clean value.
  assign bus_data   = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      req       <= 1'b0;
      count     <= '0;
      sent      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      count <= count_next;
      sent  <= pop;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);

      case (state)
        IDLE: begin
          req <= 1'b0;
          if (count_next != '0) begin
            state     <= ACTIVE;
            req       <= 1'b1;
            burst_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (pop) begin
            burst_cnt <= burst_cnt + BW'(1);
            // Tenure ends on the burst cap or when this pop drains the queue.
            if (burst_cnt == BURST_LAST || count_next == '0) begin
              req       <= 1'b0;
              burst_cnt <= '0;
              if (GAP > 0) begin
                state   <= BACKOFF;
                gap_cnt <= '0;
              end else begin
                state   <= IDLE;
              end
            end
          end
        end
        BACKOFF: begin
          req <= 1'b0;
          if (gap_cnt == GAP_LAST)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + GW'(1);
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
